evm_vote_tally: RTL and testbench
=================================

Name: evm_vote_tally

Overview:
- Parametrised vote-capture and tally engine for the EVM control unit. Generalises the fixed 4-candidate unit to N_CAND candidates, arbitrary UID width and counter width.
- Adds an explicit voter-session FSM (authenticate -> cast -> VVPAT hold), cast timeout, multi-press rejection, saturating tallies, tie detection and coded reject reasons.
- Sits between the debounced ballot buttons and voter-database lookup on one side, and the result display / password lock on the other.

Parameters:
N_CAND, 4, number of candidates (2..16)
UID_W, 6, voter ID width; the voted bitmap holds 2**UID_W entries
CNT_W, 8, per-candidate tally width (saturating)
TIMEOUT_CYC, 1000, CAST-state cycles allowed before the session aborts
HOLD_CYC, 8, cycles vvpat_valid is held after a commit (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mode  in  1  1 = voting mode, 0 = result mode
uid  in  UID_W  voter ID
enter  in  1  voter-ID submit strobe
uid_valid  in  1  voter enrolled (from the database); sampled with enter
cand_btn  in  N_CAND  debounced candidate buttons, level
unlock  in  1  password-lock open flag
sel  in  IDX_W  candidate index for readout; IDX_W = max(1,$clog2(N_CAND))
busy  out  1  session active (state != IDLE)
accepted  out  1  one-cycle pulse on commit
reject  out  1  one-cycle pulse on a rejected or aborted session
reject_code  out  3  reason for the last reject; held until the next enter
vvpat_valid  out  1  VVPAT slip active
vvpat_id  out  IDX_W  candidate just voted
sel_count  out  CNT_W  tally of candidate sel
total_votes  out  TOT_W  sum of all tallies; TOT_W = CNT_W+$clog2(N_CAND+1)
winner  out  IDX_W  index of the highest tally
tie  out  1  more than one candidate holds the maximum tally
mode_led  out  1  registered copy of mode

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all tallies, the voted bitmap, timers and uid_q cleared. All outputs 0; reject_code = 0 (NONE).
- Reject codes: 1 NOT_ENROLLED, 2 ALREADY_VOTED, 3 MULTI_PRESS, 4 TIMEOUT, 5 ABORT, 6 SATURATED.
- IDLE:
  - Acts on enter only when mode=1 and cand_btn==0; otherwise enter is ignored.
  - On enter: uid is latched to uid_q and reject_code is cleared.
  - If !uid_valid -> REJECT(1). Else if voted[uid] -> REJECT(2). Else -> CAST and the timer is cleared.
- CAST:
  - Timer increments every cycle.
  - Exactly one cand_btn bit high:
    - If that tally == 2**CNT_W-1 -> REJECT(6). Neither the tally nor voted[] changes.
    - Else -> COMMIT.
  - Two or more bits high -> REJECT(3).
  - Timer reaches TIMEOUT_CYC-1 with no press -> REJECT(4).
  - mode falls to 0 -> REJECT(5).
  - Priority when conditions coincide: ABORT > MULTI_PRESS > SATURATED > commit > TIMEOUT.
- COMMIT (1 cycle):
  - tally[idx] += 1; voted[uid_q] = 1.
  - accepted pulses.
  - vvpat_id = idx; vvpat_valid rises in this cycle.
  - -> HOLD.
- HOLD:
  - vvpat_valid stays high for HOLD_CYC cycles in total, counted from COMMIT.
  - Then waits for cand_btn==0 -> IDLE. This blocks repeat presses.
  - mode changes are ignored in HOLD; the vote is already committed.
- REJECT (1 cycle): reject pulses and reject_code is loaded -> WAIT_REL (wait for cand_btn==0) -> IDLE.
- Enter latency: enter at edge t -> busy=1 after t. Commit occurs 1 cycle after the qualifying press is sampled.
- Readout:
  - sel_count, total_votes, winner and tie are registered and update 1 cycle after any tally change or sel change.
  - They are forced to 0 unless mode=0 and unlock=1.
  - sel >= N_CAND reads 0.
  - winner is the lowest index among the maximal tallies. All-zero tallies give winner=0 and tie=1.
- voted[] persists across mode changes. Only reset_n clears it.

Optional Feature:
- Macro: EVM_NOTA_EN.
- Defined:
  - Adds input nota_btn (1 bit) and a NOTA tally at internal index N_CAND.
  - nota_btn counts as one of the buttons for single/multi-press checks.
  - vvpat_id = all-ones on a NOTA vote.
  - The NOTA tally is included in total_votes but excluded from winner and tie.
  - It is readable with sel = N_CAND, in which case IDX_W = $clog2(N_CAND+1).
- Undefined: no port and no tally are added.

Decomposition:
- Package evm_pkg holds:
  - reject-code localparams;
  - FSM state encoding (IDLE, CAST, COMMIT, HOLD, REJECT, WAIT_REL);
  - IDX_W/TOT_W width functions.
- One sub-module, evm_argmax: a combinational N-way max with lowest-index tie-break and a tie flag, registered in the parent.

Test Plan:
- Valid uid=5 with uid_valid, enter, press cand_btn=4'b0010 -> accepted pulse, vvpat_id=1 high 8 cycles; in result mode with unlock and sel=1, sel_count=1 and total_votes=1.
- Same uid=5 enters again -> reject pulse, reject_code=2, tallies unchanged.
- Enter with uid_valid=0 -> reject_code=1. Separately, valid enter then cand_btn=4'b0110 -> reject_code=3 and voted[uid] stays 0, so a retry succeeds.
- Valid enter, no press for TIMEOUT_CYC cycles -> reject_code=4 on cycle 1000; mode dropped mid-CAST -> reject_code=5.
- CNT_W=2: three votes for candidate 0, fourth voter presses 0 -> reject_code=6 and that voter can still vote for candidate 1.
- Tallies {2,2,1,0} -> winner=0, tie=1; unlock=0 -> all readouts 0; reset_n pulsed mid-HOLD -> everything 0 immediately, and a previously voted uid is accepted again.

Source files
------------

// File: rtl/evm_pkg.sv
// -----------------------------------------------------------------------------
// evm_pkg
// Shared definitions for the EVM vote-capture / tally engine:
//   - reject reason codes reported on reject_code
//   - voter-session FSM state encoding
//   - width helpers for the candidate index (IDX_W), the vote total (TOT_W)
//     and the number of internal tallies
// Build option: EVM_NOTA_EN adds a NOTA tally at internal index N_CAND, which
// widens the index so that N_CAND itself is addressable.
// -----------------------------------------------------------------------------
package evm_pkg;

   localparam logic [2:0] RC_NONE          = 3'd0;
   localparam logic [2:0] RC_NOT_ENROLLED  = 3'd1;
   localparam logic [2:0] RC_ALREADY_VOTED = 3'd2;
   localparam logic [2:0] RC_MULTI_PRESS   = 3'd3;
   localparam logic [2:0] RC_TIMEOUT       = 3'd4;
   localparam logic [2:0] RC_ABORT         = 3'd5;
   localparam logic [2:0] RC_SATURATED     = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAST,
      S_COMMIT,
      S_HOLD,
      S_REJECT,
      S_WAIT_REL
   } state_t;

   function automatic int idx_w_f(input int n_cand);
`ifdef EVM_NOTA_EN
      return ($clog2(n_cand + 1) < 1) ? 1 : $clog2(n_cand + 1);
`else
      return ($clog2(n_cand) < 1) ? 1 : $clog2(n_cand);
`endif
   endfunction

   function automatic int tot_w_f(input int cnt_w, input int n_cand);
      return cnt_w + $clog2(n_cand + 1);
   endfunction

   function automatic int n_tally_f(input int n_cand);
`ifdef EVM_NOTA_EN
      return n_cand + 1;
`else
      return n_cand;
`endif
   endfunction

endpackage

// File: rtl/evm_argmax.sv
// -----------------------------------------------------------------------------
// evm_argmax
// Combinational N-way maximum over packed unsigned values.
//   vals : N values of W bits, value i at vals[i*W +: W]
//   idx  : lowest index holding the maximum
//   tie  : more than one value equals the maximum (all-equal counts as a tie)
// -----------------------------------------------------------------------------
module evm_argmax
   import evm_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = 2
) (
   input  logic [N*W-1:0] vals,
   output logic [IW-1:0]  idx,
   output logic           tie
);

   logic [W-1:0]            best;
   logic [$clog2(N+1)-1:0]  n_best;

   always_comb begin
      best = vals[W-1:0];
      idx  = '0;
      // strict '>' keeps the earliest index on equal values
      for (int i = 1; i < N; i++) begin
         if (vals[i*W +: W] > best) begin
            best = vals[i*W +: W];
            idx  = IW'(i);
         end
      end
      n_best = '0;
      for (int i = 0; i < N; i++) begin
         if (vals[i*W +: W] == best) n_best = n_best + 1'b1;
      end
      tie = (n_best > 1);
   end

endmodule

// File: rtl/evm_vote_tally.sv
// -----------------------------------------------------------------------------
// evm_vote_tally
// Vote capture and tally engine: voter-session FSM (authenticate -> cast ->
// VVPAT hold), cast timeout, multi-press rejection, saturating tallies, tie
// detection and coded reject reasons.
// Build option: EVM_NOTA_EN adds the nota_btn input and a NOTA tally at
// internal index N_CAND (counted in total_votes, excluded from winner/tie).
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   mode                  1 = voting, 0 = result readout
//   uid, enter, uid_valid voter ID, submit strobe, enrolled flag
//   cand_btn [nota_btn]   debounced candidate buttons (level)
//   unlock, sel           readout enable and candidate index for sel_count
//   busy                  session active
//   accepted / reject     one-cycle pulses; reject_code holds the reason
//   vvpat_valid/vvpat_id  VVPAT slip and candidate just voted
//   sel_count, total_votes, winner, tie   registered, gated readouts
//   mode_led              registered copy of mode
// -----------------------------------------------------------------------------
module evm_vote_tally
   import evm_pkg::*;
#(
   parameter  int N_CAND      = 4,
   parameter  int UID_W       = 6,
   parameter  int CNT_W       = 8,
   parameter  int TIMEOUT_CYC = 1000,
   parameter  int HOLD_CYC    = 8,
   localparam int IDX_W       = idx_w_f(N_CAND),
   localparam int TOT_W       = tot_w_f(CNT_W, N_CAND)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              mode,
   input  logic [UID_W-1:0]  uid,
   input  logic              enter,
   input  logic              uid_valid,
   input  logic [N_CAND-1:0] cand_btn,
`ifdef EVM_NOTA_EN
   input  logic              nota_btn,
`endif
   input  logic              unlock,
   input  logic [IDX_W-1:0]  sel,
   output logic              busy,
   output logic              accepted,
   output logic              reject,
   output logic [2:0]        reject_code,
   output logic              vvpat_valid,
   output logic [IDX_W-1:0]  vvpat_id,
   output logic [CNT_W-1:0]  sel_count,
   output logic [TOT_W-1:0]  total_votes,
   output logic [IDX_W-1:0]  winner,
   output logic              tie,
   output logic              mode_led
);

   localparam int N_T   = n_tally_f(N_CAND);
   localparam int NV    = 2**UID_W;
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int HC_W  = $clog2(HOLD_CYC + 1);
   localparam int NP_W  = $clog2(N_T + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   state_t                  state;
   logic [CNT_W-1:0]        tally [N_T];
   logic [NV-1:0]           voted;
   logic [UID_W-1:0]        uid_q;
   logic [IDX_W-1:0]        idx_q;
   logic [TMR_W-1:0]        timer;
   logic [HC_W-1:0]         hold_cnt;

   logic [N_T-1:0]          btn;
   logic                    any_press;
   logic [NP_W-1:0]         n_press;
   logic [IDX_W-1:0]        press_idx;
   logic [IDX_W-1:0]        vid;
   logic [N_CAND*CNT_W-1:0] cand_flat;
   logic [TOT_W-1:0]        sum;
   logic [IDX_W-1:0]        am_idx;
   logic                    am_tie;

`ifdef EVM_NOTA_EN
   assign btn = {nota_btn, cand_btn};
   assign vid = (press_idx == IDX_W'(N_CAND)) ? '1 : press_idx;
`else
   assign btn = cand_btn;
   assign vid = press_idx;
`endif
   assign any_press = |btn;

   // press count plus the pressed index (exact when only one bit is set)
   always_comb begin
      n_press   = '0;
      press_idx = '0;
      for (int i = N_T - 1; i >= 0; i--) begin
         if (btn[i]) begin
            n_press   = n_press + 1'b1;
            press_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      cand_flat = '0;
      for (int i = 0; i < N_CAND; i++) cand_flat[i*CNT_W +: CNT_W] = tally[i];
      sum = '0;
      for (int i = 0; i < N_T; i++) sum = sum + TOT_W'(tally[i]);
   end

   // NOTA never enters the argmax: only the N_CAND candidate tallies are fed
   evm_argmax #(.N(N_CAND), .W(CNT_W), .IW(IDX_W)) u_argmax (
      .vals (cand_flat),
      .idx  (am_idx),
      .tie  (am_tie)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         accepted    <= 1'b0;
         reject      <= 1'b0;
         reject_code <= RC_NONE;
         vvpat_valid <= 1'b0;
         vvpat_id    <= '0;
         uid_q       <= '0;
         idx_q       <= '0;
         timer       <= '0;
         hold_cnt    <= '0;
         voted       <= '0;
         for (int i = 0; i < N_T; i++) tally[i] <= '0;
      end else begin
         accepted <= 1'b0;
         reject   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enter && mode && !any_press) begin
                  uid_q       <= uid;
                  reject_code <= RC_NONE;
                  busy        <= 1'b1;
                  if (!uid_valid) begin
                     state       <= S_REJECT;
                     reject      <= 1'b1;
                     reject_code <= RC_NOT_ENROLLED;
                  end else if (voted[uid]) begin
                     state       <= S_REJECT;
                     reject      <= 1'b1;
                     reject_code <= RC_ALREADY_VOTED;
                  end else begin
                     state <= S_CAST;
                     timer <= '0;
                  end
               end
            end
            S_CAST: begin
               timer <= timer + 1'b1;
               // branch order encodes ABORT > MULTI > SATURATED > commit > TIMEOUT
               if (!mode) begin
                  state       <= S_REJECT;
                  reject      <= 1'b1;
                  reject_code <= RC_ABORT;
               end else if (n_press > NP_W'(1)) begin
                  state       <= S_REJECT;
                  reject      <= 1'b1;
                  reject_code <= RC_MULTI_PRESS;
               end else if (n_press == NP_W'(1)) begin
                  if (tally[press_idx] == CNT_MAX) begin
                     state       <= S_REJECT;
                     reject      <= 1'b1;
                     reject_code <= RC_SATURATED;
                  end else begin
                     // outputs go high for the COMMIT cycle itself
                     state       <= S_COMMIT;
                     accepted    <= 1'b1;
                     vvpat_valid <= 1'b1;
                     vvpat_id    <= vid;
                     idx_q       <= press_idx;
                  end
               end else if (timer == TMR_LAST) begin
                  state       <= S_REJECT;
                  reject      <= 1'b1;
                  reject_code <= RC_TIMEOUT;
               end
            end
            S_COMMIT: begin
               tally[idx_q] <= tally[idx_q] + 1'b1;
               voted[uid_q] <= 1'b1;
               hold_cnt     <= HC_W'(1);
               vvpat_valid  <= (HOLD_CYC > 1);
               state        <= S_HOLD;
            end
            S_HOLD: begin
               // hold_cnt = VVPAT-high cycles already completed, COMMIT included
               if (vvpat_valid) begin
                  hold_cnt    <= hold_cnt + 1'b1;
                  vvpat_valid <= ((int'(hold_cnt) + 1) < HOLD_CYC);
               end else if (!any_press) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_REJECT: state <= S_WAIT_REL;
            S_WAIT_REL: begin
               if (!any_press) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // readouts are visible only in unlocked result mode
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_count   <= '0;
         total_votes <= '0;
         winner      <= '0;
         tie         <= 1'b0;
         mode_led    <= 1'b0;
      end else begin
         mode_led <= mode;
         if (!mode && unlock) begin
            sel_count   <= (int'(sel) < N_T) ? tally[sel] : '0;
            total_votes <= sum;
            winner      <= am_idx;
            tie         <= am_tie;
         end else begin
            sel_count   <= '0;
            total_votes <= '0;
            winner      <= '0;
            tie         <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_evm_vote_tally.sv
// -----------------------------------------------------------------------------
// tb_evm_vote_tally
// Directed scenarios followed by randomized voter sessions. A session-level
// reference model tracks tallies, the voted set and absolute-cycle deadlines;
// every falling edge all DUT outputs are compared with it. Literal checks at
// key points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_evm_vote_tally;

   localparam int N_CAND      = 4;
   localparam int UID_W       = 6;
   localparam int CNT_W       = 2;
   localparam int TIMEOUT_CYC = 1000;
   localparam int HOLD_CYC    = 8;
   localparam int IDX_W       = 2;
   localparam int TOT_W       = 5;
   localparam int CMAX        = (1 << CNT_W) - 1;

   localparam int P_IDLE = 0, P_CAST = 1, P_ACC = 2, P_HOLD = 3, P_REJ = 4, P_REL = 5;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              mode = 1'b0;
   logic [UID_W-1:0]  uid = '0;
   logic              enter = 1'b0;
   logic              uid_valid = 1'b0;
   logic [N_CAND-1:0] cand_btn = '0;
   logic              unlock = 1'b0;
   logic [IDX_W-1:0]  sel = '0;
   logic              busy, accepted, reject, vvpat_valid, tie, mode_led;
   logic [2:0]        reject_code;
   logic [IDX_W-1:0]  vvpat_id, winner;
   logic [CNT_W-1:0]  sel_count;
   logic [TOT_W-1:0]  total_votes;

   evm_vote_tally #(
      .N_CAND(N_CAND), .UID_W(UID_W), .CNT_W(CNT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clock(clock), .reset_n(reset_n), .mode(mode), .uid(uid), .enter(enter),
      .uid_valid(uid_valid), .cand_btn(cand_btn), .unlock(unlock), .sel(sel),
      .busy(busy), .accepted(accepted), .reject(reject), .reject_code(reject_code),
      .vvpat_valid(vvpat_valid), .vvpat_id(vvpat_id), .sel_count(sel_count),
      .total_votes(total_votes), .winner(winner), .tie(tie), .mode_led(mode_led)
   );

   always #5 clock = ~clock;

   int nvec = 0;
   int nmis = 0;

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_tally [N_CAND];
   bit m_voted [2**UID_W];
   int phase, cyc, cast_start, commit_cyc, m_uid, m_idx;
   int e_busy, e_acc, e_rej, e_code, e_vv, e_vid, e_sel, e_tot, e_win, e_tie, e_led;

   task automatic model_reset();
      foreach (m_tally[i]) m_tally[i] = 0;
      foreach (m_voted[i]) m_voted[i] = 1'b0;
      phase = P_IDLE; cyc = 0; cast_start = 0; commit_cyc = -1000;
      m_uid = 0; m_idx = 0;
      e_busy = 0; e_acc = 0; e_rej = 0; e_code = 0; e_vv = 0; e_vid = 0;
      e_sel = 0; e_tot = 0; e_win = 0; e_tie = 0; e_led = 0;
   endtask

   task automatic model_reject(input int code);
      phase = P_REJ; e_rej = 1; e_code = code;
   endtask

   task automatic model_step();
      int mx, nmax, sum, np, idx;
      cyc++;
      if (!mode && unlock) begin
         sum = 0; mx = 0;
         foreach (m_tally[i]) begin
            sum += m_tally[i];
            if (m_tally[i] > mx) mx = m_tally[i];
         end
         nmax = 0; e_win = -1;
         foreach (m_tally[i]) if (m_tally[i] == mx) begin
            nmax++;
            if (e_win < 0) e_win = i;
         end
         e_sel = m_tally[sel]; e_tot = sum; e_tie = (nmax > 1) ? 1 : 0;
      end else begin
         e_sel = 0; e_tot = 0; e_win = 0; e_tie = 0;
      end
      e_led = mode;
      np = $countones(cand_btn);
      idx = 0;
      for (int i = N_CAND - 1; i >= 0; i--) if (cand_btn[i]) idx = i;
      e_acc = 0; e_rej = 0;
      case (phase)
         P_IDLE: if (enter && mode && np == 0) begin
            m_uid = uid; e_code = 0;
            if (!uid_valid) model_reject(1);
            else if (m_voted[uid]) model_reject(2);
            else begin phase = P_CAST; cast_start = cyc; end
         end
         P_CAST: begin
            if (!mode) model_reject(5);
            else if (np >= 2) model_reject(3);
            else if (np == 1) begin
               if (m_tally[idx] == CMAX) model_reject(6);
               else begin
                  phase = P_ACC; e_acc = 1; e_vid = idx; m_idx = idx; commit_cyc = cyc;
               end
            end else if (cyc - cast_start >= TIMEOUT_CYC) model_reject(4);
         end
         P_ACC: begin
            m_tally[m_idx]++; m_voted[m_uid] = 1'b1; phase = P_HOLD;
         end
         P_HOLD: if ((cyc - 1 - commit_cyc) >= HOLD_CYC && np == 0) phase = P_IDLE;
         P_REJ: phase = P_REL;
         P_REL: if (np == 0) phase = P_IDLE;
         default: phase = P_IDLE;
      endcase
      e_vv = ((phase == P_ACC || phase == P_HOLD) && (cyc - commit_cyc < HOLD_CYC)) ? 1 : 0;
      e_busy = (phase != P_IDLE) ? 1 : 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clock);
         check("busy", busy, e_busy);
         check("accepted", accepted, e_acc);
         check("reject", reject, e_rej);
         check("reject_code", reject_code, e_code);
         check("vvpat_valid", vvpat_valid, e_vv);
         check("vvpat_id", vvpat_id, e_vid);
         check("sel_count", sel_count, e_sel);
         check("total_votes", total_votes, e_tot);
         check("winner", winner, e_win);
         check("tie", tie, e_tie);
         check("mode_led", mode_led, e_led);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clock);
   endtask

   task automatic do_enter(input int u, input bit v);
      uid = u[UID_W-1:0]; uid_valid = v; enter = 1'b1;
      step();
      enter = 1'b0; uid_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      cand_btn = '0;
      while (busy && n < 200) begin
         step();
         n++;
      end
      check("wait_idle_busy", busy, 0);
   endtask

   task automatic vote(input int u, input logic [N_CAND-1:0] b);
      do_enter(u, 1'b1);
      cand_btn = b;
      step();
      wait_idle();
   endtask

   task automatic show_results(input logic [IDX_W-1:0] s);
      mode = 1'b0; unlock = 1'b1; sel = s;
      step(); step();
   endtask

   initial begin
      int n;
      int u, kind;
      bit v;
      logic [N_CAND-1:0] b;

      #1 reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      check("rst_busy", busy, 0);
      check("rst_code", reject_code, 0);
      check("rst_vvpat", vvpat_valid, 0);

      // first vote: uid 5 for candidate 1
      mode = 1'b1;
      do_enter(5, 1'b1);
      check("enter_busy", busy, 1);
      cand_btn = 4'b0010;
      step();
      check("commit_accepted", accepted, 1);
      check("commit_vvpat_id", vvpat_id, 1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (vvpat_valid) n++;
         step();
      end
      check("vvpat_len", n, HOLD_CYC);
      wait_idle();
      show_results(2'd1);
      check("res_sel_count", sel_count, 1);
      check("res_total", total_votes, 1);
      check("res_winner", winner, 1);
      mode = 1'b1; unlock = 1'b0;
      step();

      // repeat voter
      do_enter(5, 1'b1);
      check("again_reject", reject, 1);
      check("again_code", reject_code, 2);
      wait_idle();

      // not enrolled, multi-press, then retry
      do_enter(9, 1'b0);
      check("notenr_code", reject_code, 1);
      wait_idle();
      do_enter(9, 1'b1);
      cand_btn = 4'b0110;
      step();
      check("multi_code", reject_code, 3);
      wait_idle();
      check("code_held", reject_code, 3);
      do_enter(9, 1'b1);
      cand_btn = 4'b0001;
      step();
      check("retry_accepted", accepted, 1);
      wait_idle();

      // timeout
      do_enter(20, 1'b1);
      n = 0;
      while (!reject && n < 1100) begin
         step();
         n++;
      end
      check("timeout_cycles", n, TIMEOUT_CYC);
      check("timeout_code", reject_code, 4);
      wait_idle();

      // abort by mode drop
      do_enter(21, 1'b1);
      step();
      mode = 1'b0;
      step();
      check("abort_code", reject_code, 5);
      mode = 1'b1;
      wait_idle();

      // saturation of candidate 0 (3 = max for CNT_W=2)
      vote(30, 4'b0001);
      vote(31, 4'b0001);
      do_enter(32, 1'b1);
      cand_btn = 4'b0001;
      step();
      check("sat_code", reject_code, 6);
      wait_idle();
      do_enter(32, 1'b1);
      cand_btn = 4'b0010;
      step();
      check("sat_retry_accepted", accepted, 1);
      wait_idle();
      show_results(2'd0);
      check("sat_sel_count", sel_count, 3);
      check("sat_total", total_votes, 5);
      mode = 1'b1; unlock = 1'b0;
      step();

      // fresh tallies {2,2,1,0}
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      vote(1, 4'b0001); vote(2, 4'b0001);
      vote(3, 4'b0010); vote(4, 4'b0010);
      vote(6, 4'b0100);
      show_results(2'd2);
      check("tie_winner", winner, 0);
      check("tie_flag", tie, 1);
      check("tie_total", total_votes, 5);
      check("tie_sel_count", sel_count, 1);
      unlock = 1'b0;
      step(); step();
      check("locked_total", total_votes, 0);
      check("locked_tie", tie, 0);
      mode = 1'b1;
      step();

      // asynchronous reset in the middle of HOLD
      do_enter(7, 1'b1);
      cand_btn = 4'b1000;
      step(); step(); step();
      check("hold_vvpat", vvpat_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_vvpat", vvpat_valid, 0);
      check("async_vvpat_id", vvpat_id, 0);
      step();
      reset_n = 1'b1; cand_btn = '0;
      step();
      do_enter(1, 1'b1);
      cand_btn = 4'b0001;
      step();
      check("revote_accepted", accepted, 1);
      wait_idle();

      // randomized sessions
      for (int s = 0; s < 60; s++) begin
         if (s == 30) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            step();
         end
         u    = $urandom_range(0, 23);
         v    = ($urandom_range(0, 9) != 0);
         kind = $urandom_range(0, 9);
         if (kind < 7) b = 4'b0001 << $urandom_range(0, 3);
         else b = 4'($urandom_range(1, 15));
         do_enter(u, v);
         repeat ($urandom_range(0, 4)) step();
         if (kind == 9) mode = 1'b0;
         cand_btn = b;
         step(); step();
         mode = 1'b1;
         wait_idle();
         if (s % 8 == 7) begin
            mode = 1'b0; unlock = 1'($urandom_range(0, 1)); sel = 2'($urandom_range(0, 3));
            step(); step();
            mode = 1'b1; unlock = 1'b0;
            step();
         end
      end
      show_results(2'($urandom_range(0, 3)));
      mode = 1'b1; unlock = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
